// File: rtl/inst_stream_gen.sv
`default_nettype none
// ============================================================================
// Module   : inst_stream_gen
// Purpose  : LFSR-driven constrained RISC-V instruction stream generator
//            with a valid/ready handshake; every emitted word is legal.
// Revision : 1.0  initial release
// ============================================================================
module inst_stream_gen #(
  parameter logic [15:0] LEN          = 16'd0,
  parameter logic [31:0] DEFAULT_SEED = 32'hACE1_2345
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        seed_load,
  input  logic [31:0] seed_in,
  input  logic        ready,
  output logic        valid,
  output logic [31:0] instruction,
  output logic        done,
  output logic [15:0] count
);

  localparam logic [1:0]  c_idle = 2'd0;
  localparam logic [1:0]  c_run  = 2'd1;
  localparam logic [1:0]  c_done = 2'd2;
  localparam logic [31:0] c_taps = 32'h8020_0003;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_lfsr;
  logic [31:0] w_lfsr_nxt;
  logic [15:0] r_count;
  logic        w_accept;
  logic        w_last;

  assign w_accept   = (r_state == c_run) && ready;
  assign w_last     = (LEN != 16'd0) && (({1'b0, r_count} + 17'd1) == {1'b0, LEN});
  assign w_lfsr_nxt = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? c_taps : 32'd0);
  assign count      = r_count;

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_idle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_run:   if (w_accept && w_last) w_state_nxt = c_done;
      default: if (start)              w_state_nxt = c_run;
    endcase
  end

  always_comb begin
    valid = (r_state == c_run);
    done  = (r_state == c_done);
  end

  // LFSR only moves on accept while running; seeding is allowed only when idle or done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr  <= DEFAULT_SEED;
      r_count <= 16'd0;
    end else if (r_state == c_run) begin
      if (ready) begin
        r_lfsr <= w_lfsr_nxt;
        if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
      end
    end else begin
      if (seed_load) r_lfsr  <= (seed_in == 32'd0) ? 32'd1 : seed_in;
      if (start)     r_count <= 16'd0;
    end
  end

  logic [3:0] w_cls;
  logic [3:0] w_k;
  logic [3:0] w_op;

  assign w_cls = r_lfsr[3:0];
  assign w_k   = r_lfsr[31:28];

  always_comb begin
    instruction = r_lfsr;
    w_op        = 4'd0;
    if (w_cls <= 4'd4) begin
      w_op = (w_k >= 4'd14) ? (w_k - 4'd14) : w_k;
      instruction[6:0]   = 7'b0110011;
      instruction[31:25] = 7'b0000000;
      case (w_op)
        4'd0:  instruction[14:12] = 3'b000;
        4'd1:  begin instruction[14:12] = 3'b000; instruction[31:25] = 7'b0100000; end
        4'd2:  instruction[14:12] = 3'b001;
        4'd3:  instruction[14:12] = 3'b010;
        4'd4:  instruction[14:12] = 3'b011;
        4'd5:  instruction[14:12] = 3'b100;
        4'd6:  instruction[14:12] = 3'b101;
        4'd7:  begin instruction[14:12] = 3'b101; instruction[31:25] = 7'b0100000; end
        4'd8:  instruction[14:12] = 3'b110;
        4'd9:  instruction[14:12] = 3'b111;
        4'd10: begin instruction[14:12] = 3'b000; instruction[31:25] = 7'b0000001; end
        4'd11: begin instruction[14:12] = 3'b001; instruction[31:25] = 7'b0000001; end
        4'd12: begin instruction[14:12] = 3'b010; instruction[31:25] = 7'b0000001; end
        default: begin instruction[14:12] = 3'b011; instruction[31:25] = 7'b0000001; end
      endcase
    end else if (w_cls <= 4'd8) begin
      w_op = (w_k >= 4'd9) ? (w_k - 4'd9) : w_k;
      instruction[6:0] = 7'b0010011;
      case (w_op)
        4'd0:  instruction[14:12] = 3'b000;
        4'd1:  instruction[14:12] = 3'b010;
        4'd2:  instruction[14:12] = 3'b011;
        4'd3:  instruction[14:12] = 3'b100;
        4'd4:  instruction[14:12] = 3'b110;
        4'd5:  instruction[14:12] = 3'b111;
        4'd6:  begin instruction[14:12] = 3'b001; instruction[31:25] = 7'b0000000; end
        4'd7:  begin instruction[14:12] = 3'b101; instruction[31:25] = 7'b0000000; end
        default: begin instruction[14:12] = 3'b101; instruction[31:25] = 7'b0100000; end
      endcase
    end else begin
      case (w_cls)
        4'd9, 4'd10: begin instruction[6:0] = 7'b0000011; instruction[14:12] = 3'b010; end
        4'd11:       begin instruction[6:0] = 7'b0100011; instruction[14:12] = 3'b010; end
        4'd12: begin
          // 010/011 are not branch encodings; fold them onto BEQ/BNE.
          instruction[6:0] = 7'b1100011;
          if (r_lfsr[14:13] == 2'b01) instruction[13] = 1'b0;
        end
        4'd13:       instruction[6:0] = 7'b1101111;
        4'd14:       begin instruction[6:0] = 7'b1100111; instruction[14:12] = 3'b000; end
        default:     instruction = 32'h0000_007F;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_stream_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_stream_gen
// Purpose  : self-checking bench for inst_stream_gen (vectors + random model)
// Revision : 1.0  initial release
// ============================================================================
module tb_inst_stream_gen;

  localparam logic [31:0] c_def_seed = 32'hACE1_2345;

  logic        clk;
  logic        reset, start, seed_load, ready;
  logic [31:0] seed_in;
  logic        valid0, done0, valid4, done4;
  logic [31:0] ins0, ins4;
  logic [15:0] cnt0, cnt4;

  inst_stream_gen #(.LEN(16'd0), .DEFAULT_SEED(c_def_seed)) dut0 (
    .clk(clk), .reset(reset), .start(start), .seed_load(seed_load), .seed_in(seed_in),
    .ready(ready), .valid(valid0), .instruction(ins0), .done(done0), .count(cnt0));

  inst_stream_gen #(.LEN(16'd4), .DEFAULT_SEED(c_def_seed)) dut4 (
    .clk(clk), .reset(reset), .start(start), .seed_load(seed_load), .seed_in(seed_in),
    .ready(ready), .valid(valid4), .instruction(ins4), .done(done4), .count(cnt4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: phase 0 idle, 1 running, 2 finished
  int          m_phase;
  logic [31:0] m_lfsr;
  logic [15:0] m_cnt;
  logic [15:0] m_len;

  logic [2:0] rf3 [14];
  logic [6:0] rf7 [14];
  logic [2:0] if3 [9];

  typedef struct { logic [31:0] seed; logic [31:0] exp; } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] adv(input logic [31:0] l);
    return (l >> 1) ^ ((l % 2 == 1) ? 32'h8020_0003 : 32'd0);
  endfunction

  function automatic logic [31:0] enc(input logic [31:0] w);
    logic [31:0] e;
    int cls, k, op;
    logic [2:0] f;
    e = w; cls = int'(w[3:0]); k = int'(w[31:28]);
    if (cls <= 4) begin
      op = k % 14;
      e[6:0] = 7'h33; e[14:12] = rf3[op]; e[31:25] = rf7[op];
    end else if (cls <= 8) begin
      op = k % 9;
      e[6:0] = 7'h13; e[14:12] = if3[op];
      if (op == 6 || op == 7) e[31:25] = 7'h00;
      if (op == 8) e[31:25] = 7'h20;
    end else if (cls <= 10) begin e[6:0] = 7'h03; e[14:12] = 3'd2;
    end else if (cls == 11) begin e[6:0] = 7'h23; e[14:12] = 3'd2;
    end else if (cls == 12) begin
      f = w[14:12];
      if (f == 3'd2) f = 3'd0;
      else if (f == 3'd3) f = 3'd1;
      e[6:0] = 7'h63; e[14:12] = f;
    end else if (cls == 13) e[6:0] = 7'h6F;
    else if (cls == 14) begin e[6:0] = 7'h67; e[14:12] = 3'd0; end
    else e = 32'h0000_007F;
    return e;
  endfunction

  // returns class index 0..8, or -1 if the word is not an accepted encoding
  function automatic int legal_class(input logic [31:0] w);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    opc = w[6:0]; f7 = w[31:25]; f3 = w[14:12];
    case (opc)
      7'h33: begin
        if (f7 == 7'h00) return 0;
        if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) return 0;
        if (f7 == 7'h01) return 1;
        return -1;
      end
      7'h13: begin
        if (f3 == 3'd1 && f7 != 7'h00) return -1;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) return -1;
        return 2;
      end
      7'h03: return (f3 == 3'd2) ? 3 : -1;
      7'h23: return (f3 == 3'd2) ? 4 : -1;
      7'h63: return (f3 == 3'd2 || f3 == 3'd3) ? -1 : 5;
      7'h6F: return 6;
      7'h67: return (f3 == 3'd0) ? 7 : -1;
      7'h7F: return (w == 32'h7F) ? 8 : -1;
      default: return -1;
    endcase
  endfunction

  task automatic model_step();
    if (reset) begin
      m_phase = 0; m_lfsr = c_def_seed; m_cnt = 16'd0;
    end else if (m_phase == 1) begin
      if (ready) begin
        m_lfsr = adv(m_lfsr);
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (m_len != 16'd0 && m_cnt == m_len) m_phase = 2;
      end
    end else begin
      if (seed_load) m_lfsr = (seed_in == 32'd0) ? 32'd1 : seed_in;
      if (start) begin m_phase = 1; m_cnt = 16'd0; end
    end
  endtask

  function automatic logic [31:0] cur_ins();
    return (m_len == 16'd0) ? ins0 : ins4;
  endfunction

  task automatic cycle();
    logic v, d;
    logic [15:0] c;
    model_step();
    @(posedge clk); #1;
    v = (m_len == 16'd0) ? valid0 : valid4;
    d = (m_len == 16'd0) ? done0  : done4;
    c = (m_len == 16'd0) ? cnt0   : cnt4;
    chk("valid", {31'd0, v}, {31'd0, m_phase == 1});
    chk("done",  {31'd0, d}, {31'd0, m_phase == 2});
    chk("count", {16'd0, c}, {16'd0, m_cnt});
    if (m_phase == 1) chk("instruction", cur_ins(), enc(m_lfsr));
  endtask

  int illegal, cls, accepts;
  logic [8:0] seen;

  initial begin
    rf3 = '{3'd0,3'd0,3'd1,3'd2,3'd3,3'd4,3'd5,3'd5,3'd6,3'd7,3'd0,3'd1,3'd2,3'd3};
    rf7 = '{7'h00,7'h20,7'h00,7'h00,7'h00,7'h00,7'h00,7'h20,7'h00,7'h00,7'h01,7'h01,7'h01,7'h01};
    if3 = '{3'd0,3'd2,3'd3,3'd4,3'd6,3'd7,3'd1,3'd5,3'd5};
    vecs[0] = '{32'h0ABC_DEF0, 32'h00BC_8EB3};
    vecs[1] = '{32'h0000_000F, 32'h0000_007F};
    vecs[2] = '{32'h0000_200C, 32'h0000_0063};
    vecs[3] = '{32'h0000_0000, 32'h0000_0033};
    vecs[4] = '{32'h4000_0005, 32'h4000_6013};
    vecs[5] = '{32'hF000_0000, 32'h4000_0033};
    vecs[6] = '{32'hA000_0008, 32'hA000_2013};
    vecs[7] = '{32'h0000_000D, 32'h0000_006F};
    vecs[8] = '{32'hFFFF_FFFE, 32'hFFFF_8FE7};
    vecs[9] = '{32'h3000_000A, 32'h3000_2003};

    m_len = 16'd0; m_phase = 0; m_lfsr = c_def_seed; m_cnt = 16'd0;
    reset = 1'b1; start = 1'b0; seed_load = 1'b0; seed_in = 32'd0; ready = 1'b0;
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    start = 1'b1; cycle(); start = 1'b0;
    chk("default_seed_ins", ins0, enc(c_def_seed));

    // seeded first-instruction vectors
    for (int i = 0; i < 10; i++) begin
      reset = 1'b1; cycle(); reset = 1'b0;
      seed_load = 1'b1; seed_in = vecs[i].seed; start = 1'b1;
      cycle();
      seed_load = 1'b0; start = 1'b0;
      chk($sformatf("vec%0d_ins", i), ins0, vecs[i].exp);
      ready = 1'b1; cycle(); ready = 1'b0;
      chk($sformatf("vec%0d_count", i), {16'd0, cnt0}, 32'd1);
    end

    // stall: ready low, seed_load/start in RUN must be ignored
    for (int i = 0; i < 5; i++) begin
      seed_load = (i == 2); start = (i == 3); seed_in = 32'h1357_9BDF;
      cycle();
    end
    seed_load = 1'b0; start = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // randomized long run from seed 0 with legality monitor
    reset = 1'b1; cycle(); reset = 1'b0;
    seed_load = 1'b1; seed_in = 32'd0; start = 1'b1; cycle();
    seed_load = 1'b0; start = 1'b0;
    illegal = 0; seen = 9'd0;
    for (int i = 0; i < 20000; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 49) == 0);
      seed_load = ($urandom_range(0, 49) == 0);
      seed_in = $urandom;
      cls = legal_class(ins0);
      if (valid0 && ready) begin
        if (cls < 0) illegal++;
        else seen[cls] = 1'b1;
      end
      cycle();
    end
    start = 1'b0; seed_load = 1'b0;
    chk("illegal_words", illegal, 0);
    chk("classes_seen", {23'd0, seen}, {23'd0, 9'h1FF});

    // LEN=4 instance
    m_len = 16'd4;
    ready = 1'b0;
    reset = 1'b1; cycle(); reset = 1'b0;
    seed_load = 1'b1; seed_in = 32'h1234_5678; start = 1'b1; cycle();
    seed_load = 1'b0; start = 1'b0;
    accepts = 0;
    for (int i = 0; i < 100 && !done4; i++) begin
      ready = $urandom_range(0, 1);
      if (valid4 && ready) accepts++;
      cycle();
    end
    chk("len4_accepts", accepts, 4);
    chk("len4_done", {31'd0, done4}, 32'd1);
    chk("len4_valid", {31'd0, valid4}, 32'd0);
    ready = 1'b1; cycle(); cycle();
    start = 1'b1; cycle(); start = 1'b0;
    chk("len4_restart_count", {16'd0, cnt4}, 32'd0);
    cycle();
    reset = 1'b1; cycle(); reset = 1'b0;
    chk("reset_midrun_valid", {31'd0, valid4}, 32'd0);
    start = 1'b1; cycle(); start = 1'b0;
    chk("reset_seed_ins", ins4, enc(c_def_seed));
    cycle(); cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
